// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational alu between two requesters, with a one-entry result buffer.
// Latency: a result appears on rsp_data one cycle after its request is accepted (reqN_valid & reqN_ready).
// Backpressure: the buffer accepts a new request when empty or when being drained the same cycle; otherwise both readys stay low.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,

    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,

    // shared combinational alu
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_out,

    // buffered response
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);

    // Result buffer occupancy.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;
    logic       last_grant;   // index of the requester granted most recently
    logic       can_accept;
    logic       pick0;
    logic       grant0;
    logic       grant1;
    logic       grant_any;

    // The buffer can take a new result when empty, or when its current result leaves this cycle.
    // Reset gates everything so no request is acknowledged while rst is high.
    always_comb begin
        can_accept = 1'b0;
        if (!rst) begin
            can_accept = (state == EMPTY) || rsp_ready;
        end
    end

    // Single requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        pick0     = req0_valid && (!req1_valid || last_grant);
        grant0    = can_accept && pick0;
        grant1    = can_accept && req1_valid && !pick0;
        grant_any = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the granted requester's operation onto the alu; park the alu at zero otherwise.
    always_comb begin
        alu_op = 3'd0;
        alu_x  = '0;
        alu_y  = '0;
        if (grant0) begin
            alu_op = req0_op;
            alu_x  = req0_x;
            alu_y  = req0_y;
        end else if (grant1) begin
            alu_op = req1_op;
            alu_x  = req1_x;
            alu_y  = req1_y;
        end
    end

    // Buffer state: load on grant (also when draining, for full throughput), empty on drain alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else if (grant_any) begin
            state <= FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state <= EMPTY;
        end
    end

    // Captured result and owner; held untouched unless a new grant lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else if (grant_any) begin
            rsp_data <= alu_out;
            rsp_id   <= grant1;
        end
    end

    // Round-robin pointer; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_any) begin
            last_grant <= grant1;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_x, alu_y, alu_out;
    logic         rsp_valid, rsp_id, rsp_ready;
    logic [W-1:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        case (op)
            3'd1:    return x + y;
            3'd2:    return x - y;
            3'd3:    return (x < y) ? {{(W-1){1'b0}}, 1'b1} : '0;
            default: return '0;
        endcase
    endfunction

    // The shared alu lives outside the arbiter.
    always_comb alu_out = ref_alu(alu_op, alu_x, alu_y);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        end else begin
            chk("rsp_valid_vs_sb", {63'd0, rsp_valid}, {63'd0, sb.size() != 0});
            chk("single_grant", {63'd0, req0_ready & req1_ready}, 64'd0);
            chk("ready_needs_valid", {62'd0, req1_ready & ~req1_valid, req0_ready & ~req0_valid}, 64'd0);
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_id", {63'd0, rsp_id}, {63'd0, e.id});
                chk("sb_data", {32'd0, rsp_data}, {32'd0, e.data});
            end
            if (req0_valid && req0_ready) sb.push_back('{1'b0, ref_alu(req0_op, req0_x, req0_y)});
            if (req1_valid && req1_ready) sb.push_back('{1'b1, ref_alu(req1_op, req1_x, req1_y)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        req0_valid = v; req0_op = op; req0_x = x; req0_y = y;
    endtask

    task automatic set1(input logic v, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        req1_valid = v; req1_op = op; req1_x = x; req1_y = y;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesters shouting: nothing may be acknowledged.
        rst = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b1, 3'd1, 32'd3, 32'd4);
        set1(1'b1, 3'd2, 32'd9, 32'd1);
        #3;
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("reset_req0_ready", {63'd0, req0_ready}, 64'd0);
        chk("reset_req1_ready", {63'd0, req1_ready}, 64'd0);
        chk("reset_alu_op", {61'd0, alu_op}, 64'd0);
        chk("reset_alu_x", {32'd0, alu_x}, 64'd0);
        chk("reset_alu_y", {32'd0, alu_y}, 64'd0);
        cyc();

        // Single request, accepted on the first edge after reset release.
        rst = 1'b0;
        set0(1'b1, 3'd1, 32'd5, 32'd7);
        set1(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("single_req0_ready", {63'd0, req0_ready}, 64'd1);
        chk("single_alu_op", {61'd0, alu_op}, 64'd1);
        chk("single_alu_x", {32'd0, alu_x}, 64'd5);
        chk("single_alu_y", {32'd0, alu_y}, 64'd7);
        cyc();
        set0(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("single_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("single_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("single_rsp_data", {32'd0, rsp_data}, 64'd12);
        chk("idle_alu_op", {61'd0, alu_op}, 64'd0);
        cyc();
        chk("drain_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("drain_hold_data", {32'd0, rsp_data}, 64'd12);
        cyc();
        chk("empty_rsp_ready_noeffect", {63'd0, rsp_valid}, 64'd0);

        // Short reset pulse between edges so the tie pointer starts fresh.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        cyc();

        // Ties alternate, starting with requester 0.
        set0(1'b1, 3'd2, 32'd10, 32'd3);
        set1(1'b1, 3'd3, 32'd3, 32'd5);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("tie_req0_ready", {63'd0, req0_ready}, {63'd0, (k % 2) == 0});
            chk("tie_req1_ready", {63'd0, req1_ready}, {63'd0, (k % 2) == 1});
            cyc();
            chk("tie_rsp_id", {63'd0, rsp_id}, {63'd0, (k % 2) == 1});
            chk("tie_rsp_data", {32'd0, rsp_data}, ((k % 2) == 0) ? 64'd7 : 64'd1);
        end

        // Backpressure: FULL with 12, consumer stalls, req1 waiting.
        set1(1'b0, 3'd0, 32'd0, 32'd0);
        set0(1'b1, 3'd1, 32'd5, 32'd7);
        cyc();
        set0(1'b0, 3'd0, 32'd0, 32'd0);
        set1(1'b1, 3'd1, 32'd20, 32'd22);
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_data", {32'd0, rsp_data}, 64'd12);
            chk("bp_rsp_id", {63'd0, rsp_id}, 64'd0);
            chk("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
            chk("bp_alu_op", {61'd0, alu_op}, 64'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req1_ready", {63'd0, req1_ready}, 64'd1);
        cyc();
        set1(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("bp_new_rsp_id", {63'd0, rsp_id}, 64'd1);
        chk("bp_new_rsp_data", {32'd0, rsp_data}, 64'd42);
        cyc();

        // Back-to-back stream from requester 0.
        for (int i = 1; i <= 3; i++) begin
            set0(1'b1, 3'd1, W'(i), W'(i));
            cyc();
            chk("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("b2b_rsp_data", {32'd0, rsp_data}, 64'(2 * i));
        end
        set0(1'b0, 3'd0, 32'd0, 32'd0);
        cyc();
        chk("b2b_drained", {63'd0, rsp_valid}, 64'd0);

        // Asynchronous reset while FULL discards the result before the next edge.
        rsp_ready = 1'b0;
        set0(1'b1, 3'd1, 32'd5, 32'd7);
        cyc();
        set0(1'b0, 3'd0, 32'd0, 32'd0);
        chk("mid_full", {63'd0, rsp_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        cyc();
        rst = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("post_rst_no_stale", {63'd0, rsp_valid}, 64'd0);

        // Undefined opcode and ZERO both produce 0.
        set1(1'b1, 3'd5, 32'd9, 32'd9);
        #1;
        chk("op5_req1_ready", {63'd0, req1_ready}, 64'd1);
        cyc();
        set1(1'b0, 3'd0, 32'd0, 32'd0);
        set0(1'b1, 3'd0, 32'd3, 32'd4);
        #1;
        chk("op5_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("op5_rsp_id", {63'd0, rsp_id}, 64'd1);
        cyc();
        set0(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("zero_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("zero_rsp_id", {63'd0, rsp_id}, 64'd0);
        cyc();
        cyc();
        chk("sb_empty_at_end", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width shared with the alu.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1, meaning requester n presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1, meaning requester n's operation is accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op, input, 3, the operation code (0 ZERO, 1 ADD, 2 SUBSTRACT, 3 LESSTHAN, 4-7 yield 0).
REQ-007 SHALL have ports req0_x/req0_y/req1_x/req1_y, input, WIDTH, the operands.
REQ-008 SHALL have ports alu_op (output, 3), alu_x and alu_y (output, WIDTH), driving the shared combinational alu.
REQ-009 SHALL have port alu_out, input, WIDTH, the shared alu's combinational result.
REQ-010 SHALL have port rsp_valid, output, 1, meaning the result buffer holds a result.
REQ-011 SHALL have port rsp_id, output, 1, meaning the requester index that owns the buffered result.
REQ-012 SHALL have port rsp_data, output, WIDTH, the buffered result.
REQ-013 SHALL have port rsp_ready, input, 1, meaning the consumer takes the result this cycle.

Function
REQ-014 SHALL contain a one-entry result buffer with states EMPTY and FULL.
REQ-015 SHALL compute can_accept = EMPTY, or (FULL and rsp_ready).
REQ-016 SHALL grant at most one requester per cycle, and only when can_accept=1 and that requester's valid=1.
REQ-017 When only one requester is valid, SHALL grant that requester.
REQ-018 When both are valid, SHALL grant the requester not granted most recently (round-robin pointer last_grant).
REQ-019 SHALL update last_grant only on a grant.
REQ-020 SHALL assert reqN_ready combinationally in the same cycle as a grant to requester N, and SHALL deassert it otherwise.
REQ-021 During a grant, SHALL drive alu_op/alu_x/alu_y from the granted requester.
REQ-022 With no grant, SHALL drive alu_op=0, alu_x=0 and alu_y=0.
REQ-023 On a granted edge, SHALL capture alu_out into rsp_data and the granted index into rsp_id, and SHALL set state FULL.
REQ-024 Results SHALL appear at rsp_data one cycle after acceptance (latency 1).
REQ-025 In FULL with rsp_ready=1 and no grant, SHALL go to EMPTY and SHALL hold rsp_data/rsp_id.
REQ-026 In FULL with rsp_ready=1 and a grant, SHALL stay FULL and load the new result (full throughput, no bubble).
REQ-027 In FULL with rsp_ready=0, SHALL hold rsp_valid, rsp_data and rsp_id stable.
REQ-028 In FULL with rsp_ready=0, SHALL keep both readys low.
REQ-029 rsp_valid SHALL equal (state==FULL).
REQ-030 SHALL keep rsp_data and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-031 rsp_ready while EMPTY SHALL have no effect.
REQ-032 A requester SHALL NOT be starved: with both valid continuously and rsp_ready=1, grants SHALL strictly alternate.
REQ-033 Widths SHALL pass through unchanged; the arbiter SHALL NOT perform any arithmetic itself.

Reset
REQ-034 On rst=1, SHALL immediately set: state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (so req0 wins the first tie).
REQ-035 While rst=1, SHALL hold req0_ready=0, req1_ready=0 and alu_op/alu_x/alu_y=0, regardless of the valid inputs.
REQ-036 rst asserted mid-transaction SHALL discard the buffered result.
REQ-037 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-038 Single request: req0 ADD x=5 y=7, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12.
REQ-039 Tie after reset: both valid (req0 SUBSTRACT 10,3; req1 LESSTHAN 3,5), rsp_ready=1 -> responses in order id0 data 7, then id1 data 1; repeated ties alternate 1,0,1,...
REQ-040 Backpressure: FULL with rsp_data=12 and rsp_ready=0 for 4 cycles while req1 valid -> rsp_data stays 12, req1_ready=0; on rsp_ready=1, req1 is granted that same cycle.
REQ-041 Back-to-back: req0 streams ADD 1+1, 2+2, 3+3 with rsp_ready=1 -> rsp_valid high 3 consecutive cycles, data 2, 4, 6.
REQ-042 Reset mid-operation: FULL, assert rst asynchronously between edges -> rsp_valid=0 and rsp_data=0 before the next edge; no stale response after release.
REQ-043 Opcode edge: req1 op=5 x=9 y=9 -> rsp_data=0, rsp_id=1; ZERO op -> rsp_data=0.
